// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the iterative divider: stalls the pipeline, drives the
// divider handshake and returns {remainder, quotient} to HI/LO as one write.
`timescale 1ns/1ps
module div_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter bit ZERO_BYPASS    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_div_req,
    input  logic        i_div_signed,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic        i_flush,
    output logic        o_stall_req,
    output logic        o_div_start,
    output logic        o_div_annul,
    output logic        o_div_signed,
    output logic [31:0] o_div_op1,
    output logic [31:0] o_div_op2,
    input  logic [63:0] i_div_result,
    input  logic        i_div_ready,
    output logic        o_hilo_we,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_count;
    logic [63:0]   r_result;
    logic          r_divAnnul;
    logic          r_divSigned;
    logic [31:0]   r_divOp1;
    logic [31:0]   r_divOp2;
    logic          r_timeout;

    logic w_accept;
    logic w_zeroBypass;
    logic w_readyTaken;
    logic w_timeoutHit;
    logic w_annulNext;

    assign w_accept     = (r_state == IDLE) && i_div_req && !i_flush;
    assign w_zeroBypass = w_accept && (i_rt == 32'd0) && ZERO_BYPASS;
    // Flush outranks ready, and ready outranks the watchdog.
    assign w_readyTaken = (r_state == BUSY) && !i_flush && i_div_ready;
    assign w_timeoutHit = (r_state == BUSY) && !i_flush && !i_div_ready
                          && (r_count == CW'(TIMEOUT_CYCLES - 1));
    assign w_annulNext  = (r_state == BUSY) && (i_flush || w_timeoutHit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_zeroBypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (i_flush || w_timeoutHit) begin
                    w_nextState = IDLE;
                end else if (w_readyTaken) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A flush during DONE kills the write of the instruction being retired.
    always_comb begin
        o_stall_req = w_accept || (r_state == BUSY);
        o_hilo_we   = (r_state == DONE) && !i_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_result    <= 64'd0;
            r_divAnnul  <= 1'b0;
            r_divSigned <= 1'b0;
            r_divOp1    <= 32'd0;
            r_divOp2    <= 32'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_divAnnul <= w_annulNext;
            if (w_accept) begin
                r_divOp1    <= i_rs;
                r_divOp2    <= i_rt;
                r_divSigned <= i_div_signed;
                r_count     <= '0;
            end else if (r_state == BUSY) begin
                r_count <= r_count + 1'b1;
            end
            if (w_zeroBypass) begin
                r_result <= 64'd0;
            end else if (w_readyTaken) begin
                r_result <= i_div_result;
            end
            if (w_timeoutHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Start is high for exactly the BUSY cycles, so it can never overlap annul.
    assign o_div_start  = (r_state == BUSY);
    assign o_div_annul  = r_divAnnul;
    assign o_div_signed = r_divSigned;
    assign o_div_op1    = r_divOp1;
    assign o_div_op2    = r_divOp2;
    assign o_hi         = r_result[63:32];
    assign o_lo         = r_result[31:0];
    assign o_timeout    = r_timeout;

endmodule
